// File: rtl/player_supervisor.sv
// Game-flow controller for the player object: sequences idle, respawn, play,
// death, goal and game-over, keeps lives and score, and gates player movement.
module player_supervisor #(
  parameter int H_MIN      = 128,
  parameter int H_MAX      = 500,
  parameter int V_MIN      = 12,
  parameter int V_MAX      = 456,
  parameter int STEP       = 12,
  parameter int LIVES      = 3,
  parameter int HOLD_TICKS = 16
) (
  input  logic        slowClk,
  input  logic        rst,
  input  logic [11:0] hPos,
  input  logic [11:0] vPos,
  input  logic        player_dead,
  input  logic [3:0]  btns,
  output logic        upEnable,
  output logic        downEnable,
  output logic        leftEnable,
  output logic        rightEnable,
  output logic        playerDisable,
  output logic        playerRst,
  output logic [2:0]  lives,
  output logic [7:0]  score,
  output logic [2:0]  state,
  output logic        gameOver
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RESPAWN = 3'd1;
  localparam logic [2:0] ST_PLAY    = 3'd2;
  localparam logic [2:0] ST_DYING   = 3'd3;
  localparam logic [2:0] ST_GOAL    = 3'd4;
  localparam logic [2:0] ST_OVER    = 3'd5;

  localparam int              HOLD_W    = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  localparam logic [2:0]  LIVES_INIT = 3'(LIVES);
  localparam logic [11:0] V_GOAL     = 12'(V_MIN);
  localparam logic [11:0] V_START    = 12'(V_MAX);

  // Movement limits widened to 13 bits so pos+STEP can never wrap.
  localparam logic [12:0] UP_LIMIT    = 13'(V_MIN + STEP);
  localparam logic [12:0] DOWN_LIMIT  = 13'(V_MAX);
  localparam logic [12:0] LEFT_LIMIT  = 13'(H_MIN + STEP);
  localparam logic [12:0] RIGHT_LIMIT = 13'(H_MAX);
  localparam logic [12:0] STEP13      = 13'(STEP);

  logic              btns_prev;
  logic              any_btn;
  logic              press;
  logic [11:0]       best_v;
  logic [HOLD_W-1:0] hold_cnt;

  logic [2:0]        state_next;
  logic [2:0]        lives_next;
  logic [7:0]        score_next;
  logic [11:0]       best_next;
  logic [HOLD_W-1:0] hold_next;

  logic [12:0]       h_wide;
  logic [12:0]       v_wide;
  logic              up_ok;
  logic              down_ok;
  logic              left_ok;
  logic              right_ok;
  logic              play_next;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  // Rising-edge detect on "any button", so holding a button never restarts.
  always_comb begin
    any_btn = |btns;
    press   = any_btn & ~btns_prev;
  end

  // Position limit checks that become the movement enables one tick later.
  always_comb begin
    h_wide   = {1'b0, hPos};
    v_wide   = {1'b0, vPos};
    up_ok    = v_wide >= UP_LIMIT;
    down_ok  = (v_wide + STEP13) <= DOWN_LIMIT;
    left_ok  = h_wide >= LEFT_LIMIT;
    right_ok = (h_wide + STEP13) <= RIGHT_LIMIT;
  end

  // Game sequencing: next state, lives, score, best row and hold counter.
  always_comb begin
    state_next = state;
    lives_next = lives;
    score_next = score;
    best_next  = best_v;
    hold_next  = hold_cnt;
    case (state)
      ST_IDLE: begin
        if (press) begin
          lives_next = LIVES_INIT;
          score_next = 8'd0;
          state_next = ST_RESPAWN;
        end
      end
      ST_RESPAWN: begin
        best_next  = V_START;
        state_next = ST_PLAY;
      end
      ST_PLAY: begin
        if (player_dead) begin
          if (lives != 3'd0) lives_next = lives - 3'd1;
          hold_next  = '0;
          state_next = ST_DYING;
        end else if (vPos == V_GOAL) begin
          score_next = sat_add(score, 8'd10);
          hold_next  = '0;
          state_next = ST_GOAL;
        end else if (vPos < best_v) begin
          score_next = sat_add(score, 8'd1);
          best_next  = vPos;
        end
      end
      ST_DYING: begin
        if (hold_cnt == HOLD_LAST) begin
          state_next = (lives == 3'd0) ? ST_OVER : ST_RESPAWN;
        end else begin
          hold_next = hold_cnt + HOLD_ONE;
        end
      end
      ST_GOAL: begin
        if (hold_cnt == HOLD_LAST) begin
          state_next = ST_RESPAWN;
        end else begin
          hold_next = hold_cnt + HOLD_ONE;
        end
      end
      ST_OVER: begin
        if (press) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    play_next = (state_next == ST_PLAY);
  end

  // Register state and all outputs; outputs are decoded from the upcoming state.
  // The button history keeps tracking during reset so a button held through
  // reset release does not count as a fresh press.
  always_ff @(posedge slowClk) begin
    btns_prev <= any_btn;
    if (rst) begin
      state         <= ST_IDLE;
      lives         <= 3'd0;
      score         <= 8'd0;
      best_v        <= V_START;
      hold_cnt      <= '0;
      playerDisable <= 1'b1;
      playerRst     <= 1'b0;
      gameOver      <= 1'b0;
      upEnable      <= 1'b0;
      downEnable    <= 1'b0;
      leftEnable    <= 1'b0;
      rightEnable   <= 1'b0;
    end else begin
      state         <= state_next;
      lives         <= lives_next;
      score         <= score_next;
      best_v        <= best_next;
      hold_cnt      <= hold_next;
      playerDisable <= ~play_next;
      playerRst     <= (state_next == ST_RESPAWN);
      gameOver      <= (state_next == ST_OVER);
      upEnable      <= play_next & up_ok;
      downEnable    <= play_next & down_ok;
      leftEnable    <= play_next & left_ok;
      rightEnable   <= play_next & right_ok;
    end
  end

endmodule

// File: tb/tb_player_supervisor.sv
// Testbench for player_supervisor: directed game scenarios plus randomized play
// compared every tick against a behavioural game model.
module tb_player_supervisor;

  localparam int H_MIN = 128;
  localparam int H_MAX = 500;
  localparam int V_MIN = 12;
  localparam int V_MAX = 456;
  localparam int STEP  = 12;
  localparam int LIVES = 3;
  localparam int HOLD  = 16;

  localparam int M_IDLE = 0, M_RESPAWN = 1, M_PLAY = 2, M_DYING = 3, M_GOAL = 4, M_OVER = 5;

  logic        slowClk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] hPos = 12'd128;
  logic [11:0] vPos = 12'd456;
  logic        player_dead = 1'b0;
  logic [3:0]  btns = 4'd0;
  logic        upEnable, downEnable, leftEnable, rightEnable;
  logic        playerDisable, playerRst, gameOver;
  logic [2:0]  lives, state;
  logic [7:0]  score;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model of the game (countdown hold, plain integers).
  int m_mode = M_IDLE;
  int m_lives = 0;
  int m_score = 0;
  int m_best = V_MAX;
  int m_hold_left = 0;
  bit m_prev_any = 1'b0;
  bit m_up = 0, m_down = 0, m_left = 0, m_right = 0;
  bit m_dis = 1, m_prst = 0, m_over = 0;

  logic [20:0] dut_obs;
  logic [20:0] mdl_obs;

  player_supervisor dut (
    .slowClk(slowClk), .rst(rst), .hPos(hPos), .vPos(vPos),
    .player_dead(player_dead), .btns(btns),
    .upEnable(upEnable), .downEnable(downEnable),
    .leftEnable(leftEnable), .rightEnable(rightEnable),
    .playerDisable(playerDisable), .playerRst(playerRst),
    .lives(lives), .score(score), .state(state), .gameOver(gameOver)
  );

  // Tick clock.
  always #5 slowClk = ~slowClk;

  // Packed views of observed and predicted outputs.
  always_comb begin
    dut_obs = {state, lives, score, upEnable, downEnable, leftEnable, rightEnable,
               playerDisable, playerRst, gameOver};
    mdl_obs = {3'(m_mode), 3'(m_lives), 8'(m_score), m_up, m_down, m_left, m_right,
               m_dis, m_prst, m_over};
  end

  // Advance the model by one game tick using the inputs about to be sampled,
  // then let the DUT take that same edge and stop at the following negedge.
  task automatic tick();
    bit pressed;
    bit any;
    bit playing;
    any = (btns != 4'd0);
    pressed = any && !m_prev_any;
    m_prev_any = any;
    if (rst) begin
      m_mode = M_IDLE; m_lives = 0; m_score = 0; m_best = V_MAX; m_hold_left = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (pressed) begin m_lives = LIVES; m_score = 0; m_mode = M_RESPAWN; end
        M_RESPAWN: begin m_best = V_MAX; m_mode = M_PLAY; end
        M_PLAY: begin
          if (player_dead) begin
            if (m_lives > 0) m_lives = m_lives - 1;
            m_hold_left = HOLD; m_mode = M_DYING;
          end else if (int'(vPos) == V_MIN) begin
            m_score = (m_score + 10 > 255) ? 255 : m_score + 10;
            m_hold_left = HOLD; m_mode = M_GOAL;
          end else if (int'(vPos) < m_best) begin
            m_score = (m_score + 1 > 255) ? 255 : m_score + 1;
            m_best = int'(vPos);
          end
        end
        M_DYING, M_GOAL: begin
          m_hold_left = m_hold_left - 1;
          if (m_hold_left == 0)
            m_mode = (m_mode == M_DYING && m_lives == 0) ? M_OVER : M_RESPAWN;
        end
        M_OVER: if (pressed) m_mode = M_IDLE;
        default: m_mode = M_IDLE;
      endcase
    end
    playing = (m_mode == M_PLAY);
    m_up    = playing && (int'(vPos) >= V_MIN + STEP);
    m_down  = playing && (int'(vPos) + STEP <= V_MAX);
    m_left  = playing && (int'(hPos) >= H_MIN + STEP);
    m_right = playing && (int'(hPos) + STEP <= H_MAX);
    m_dis   = !playing;
    m_prst  = (m_mode == M_RESPAWN);
    m_over  = (m_mode == M_OVER);
    @(negedge slowClk);
  endtask

  // Reset and launch a fresh game; returns on the first PLAY tick.
  task automatic start_game();
    rst = 1'b1; btns = 4'd0; player_dead = 1'b0; hPos = 12'd128; vPos = 12'd456;
    tick(); tick();
    rst = 1'b0;
    tick();
    btns = 4'b0001;
    tick();
    btns = 4'd0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; btns = 4'b1111;
    tick(); tick();
    vectors++;
    if ({state, playerDisable, lives, score, upEnable, downEnable, leftEnable, rightEnable, playerRst, gameOver}
        !== {3'd0, 1'b1, 3'd0, 8'd0, 4'b0000, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_values got state=%0d dis=%b lives=%0d score=%0d en=%b%b%b%b prst=%b over=%b want 0/1/0/0/0000/0/0",
               state, playerDisable, lives, score, upEnable, downEnable, leftEnable, rightEnable, playerRst, gameOver);
    end
    rst = 1'b0;
    tick(); tick();
    vectors++;
    if (state !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL held_btn_no_start got state=%0d want 0", state);
    end
    vectors++;
    if (dut_obs !== mdl_obs) begin
      miscompares++;
      $display("[TB] FAIL reset_model got %h want %h", dut_obs, mdl_obs);
    end
    btns = 4'd0;
    tick();
  endtask

  task automatic test_start();
    hPos = 12'd128; vPos = 12'd456;
    btns = 4'b0001;
    tick();
    vectors++;
    if ({state, playerRst, lives} !== {3'd1, 1'b1, 3'd3}) begin
      miscompares++;
      $display("[TB] FAIL start_respawn got state=%0d prst=%b lives=%0d want 1/1/3", state, playerRst, lives);
    end
    btns = 4'd0;
    tick();
    vectors++;
    if ({state, playerRst, playerDisable} !== {3'd2, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL start_play got state=%0d prst=%b dis=%b want 2/0/0", state, playerRst, playerDisable);
    end
  endtask

  task automatic test_bounds();
    start_game();
    vectors++;
    if ({upEnable, downEnable, leftEnable, rightEnable} !== 4'b1001) begin
      miscompares++;
      $display("[TB] FAIL bounds_start_corner got udlr=%b%b%b%b want 1001", upEnable, downEnable, leftEnable, rightEnable);
    end
    hPos = 12'd500; vPos = 12'd24;
    tick();
    vectors++;
    if ({upEnable, downEnable, leftEnable, rightEnable} !== 4'b1110) begin
      miscompares++;
      $display("[TB] FAIL bounds_right_edge got udlr=%b%b%b%b want 1110", upEnable, downEnable, leftEnable, rightEnable);
    end
    vectors++;
    if (dut_obs !== mdl_obs) begin
      miscompares++;
      $display("[TB] FAIL bounds_model got %h want %h", dut_obs, mdl_obs);
    end
  endtask

  task automatic test_progress_goal();
    start_game();
    vPos = 12'd444; tick();
    vPos = 12'd432; tick();
    vectors++;
    if (score !== 8'd2) begin
      miscompares++;
      $display("[TB] FAIL progress_score got %0d want 2", score);
    end
    vPos = 12'd12; tick();
    vectors++;
    if ({state, score} !== {3'd4, 8'd12}) begin
      miscompares++;
      $display("[TB] FAIL goal_entry got state=%0d score=%0d want 4/12", state, score);
    end
    vPos = 12'd456;
    for (int i = 1; i < HOLD; i++) begin
      tick();
      vectors++;
      if (state !== 3'd4) begin
        miscompares++;
        $display("[TB] FAIL goal_hold tick %0d got state=%0d want 4", i, state);
      end
    end
    tick();
    vectors++;
    if ({state, lives} !== {3'd1, 3'd3}) begin
      miscompares++;
      $display("[TB] FAIL goal_exit got state=%0d lives=%0d want 1/3", state, lives);
    end
  endtask

  task automatic test_death();
    logic [2:0] want_lives;
    start_game();
    for (int k = 0; k < 3; k++) begin
      want_lives = 3'(2 - k);
      player_dead = 1'b1; tick(); player_dead = 1'b0;
      vectors++;
      if ({state, lives} !== {3'd3, want_lives}) begin
        miscompares++;
        $display("[TB] FAIL death_%0d got state=%0d lives=%0d want 3/%0d", k, state, lives, want_lives);
      end
      repeat (HOLD) tick();
      vectors++;
      if (dut_obs !== mdl_obs) begin
        miscompares++;
        $display("[TB] FAIL death_exit_%0d got %h want %h", k, dut_obs, mdl_obs);
      end
      if (k < 2) tick();
    end
    vectors++;
    if ({state, gameOver, playerDisable} !== {3'd5, 1'b1, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL game_over got state=%0d over=%b dis=%b want 5/1/1", state, gameOver, playerDisable);
    end
    btns = 4'b0100; tick(); btns = 4'd0;
    vectors++;
    if ({state, gameOver} !== {3'd0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL over_to_idle got state=%0d over=%b want 0/0", state, gameOver);
    end
    start_game();
    vPos = 12'd444; tick();
    player_dead = 1'b1; vPos = 12'd12; tick();
    player_dead = 1'b0; vPos = 12'd456;
    vectors++;
    if ({state, score, lives} !== {3'd3, 8'd1, 3'd2}) begin
      miscompares++;
      $display("[TB] FAIL death_beats_goal got state=%0d score=%0d lives=%0d want 3/1/2", state, score, lives);
    end
  endtask

  task automatic test_reset_mid_dying();
    start_game();
    player_dead = 1'b1; tick(); player_dead = 1'b0;
    repeat (7) tick();
    rst = 1'b1; tick();
    vectors++;
    if ({state, playerDisable, playerRst, lives, score, upEnable, downEnable, leftEnable, rightEnable, gameOver}
        !== {3'd0, 1'b1, 1'b0, 3'd0, 8'd0, 4'b0000, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_dying got state=%0d dis=%b lives=%0d score=%0d", state, playerDisable, lives, score);
    end
    rst = 1'b0; tick();
    btns = 4'b1000; tick(); btns = 4'd0;
    vectors++;
    if ({state, lives} !== {3'd1, 3'd3}) begin
      miscompares++;
      $display("[TB] FAIL restart_after_reset got state=%0d lives=%0d want 1/3", state, lives);
    end
    tick();
  endtask

  task automatic test_random();
    int walk_v;
    int r;
    walk_v = V_MAX;
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      btns = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0;
      player_dead = ($urandom_range(0, 39) == 0);
      r = $urandom_range(0, 99);
      if (r < 60) walk_v = walk_v - STEP;
      else if (r < 80) walk_v = walk_v + STEP;
      if (walk_v < V_MIN) walk_v = V_MAX;
      if (walk_v > V_MAX) walk_v = V_MAX;
      vPos = ($urandom_range(0, 19) == 0) ? 12'($urandom) : 12'(walk_v);
      hPos = ($urandom_range(0, 9) == 0) ? 12'($urandom) : 12'(H_MIN + STEP * $urandom_range(0, 31));
      tick();
      vectors++;
      if (dut_obs !== mdl_obs) begin
        miscompares++;
        $display("[TB] FAIL random_tick %0d got %h want %h", i, dut_obs, mdl_obs);
      end
    end
    rst = 1'b0; btns = 4'd0; player_dead = 1'b0;
  endtask

  initial begin
    @(negedge slowClk);
    test_reset();
    test_start();
    test_bounds();
    test_progress_goal();
    test_death();
    test_reset_mid_dying();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/player_supervisor.md
# player_supervisor

Game-flow controller on the far side of the player object's control interface. It consumes the player's reported position (`hPos`, `vPos`) and `player_dead`, and produces the movement enables, `playerDisable` and a position-reset pulse that drive the player object. It also owns lives, score and the idle/play/death/goal/game-over sequencing. It runs on the game tick clock alongside the player and obstacle objects.

## Interface

Parameters:
- `H_MIN`, 128: leftmost legal player hPos (px)
- `H_MAX`, 500: rightmost legal player hPos (128+12*31)
- `V_MIN`, 12: topmost legal vPos; also the goal row
- `V_MAX`, 456: bottom (start) row vPos (12+37*12)
- `STEP`, 12: grid pitch in px
- `LIVES`, 3: lives loaded at game start (1..7)
- `HOLD_TICKS`, 16: ticks spent in DYING and GOAL (≥1)

Ports:
- `slowClk` in 1: game tick clock; all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `hPos` in 12: player horizontal position
- `vPos` in 12: player vertical position
- `player_dead` in 1: level, high while player is overlapping a hazard
- `btns` in 4: raw game buttons; any press starts a game
- `upEnable`, `downEnable`, `leftEnable`, `rightEnable` out 1 each: movement permitted
- `playerDisable` out 1: freezes/blanks player
- `playerRst` out 1: one-tick pulse, returns player to start position
- `lives` out 3: remaining lives
- `score` out 8: saturating score
- `state` out 3: IDLE=0, RESPAWN=1, PLAY=2, DYING=3, GOAL=4, OVER=5
- `gameOver` out 1: high in OVER

## Operation

- Start detect: `press = (|btns) & ~btnsPrev`. `btnsPrev` is a register of `|btns`, so a held button does not retrigger.
- IDLE: `playerDisable`=1, enables 0. On `press`: lives←LIVES, score←0, go to RESPAWN.
- RESPAWN: exactly one tick. `playerRst`=1, `bestV`←V_MAX, then go to PLAY.
- PLAY: `playerDisable`=0.
  - If `player_dead`: lives←lives−1, go to DYING.
  - Else if `vPos`==V_MIN: score←sat(score+10), go to GOAL.
  - Else if `vPos`<`bestV`: score←sat(score+1), `bestV`←`vPos` (forward-progress credit).
  - Death has priority over goal and progress in the same tick.
- DYING: `playerDisable`=1, enables 0, hold counter runs. After HOLD_TICKS ticks: go to OVER if lives==0, else RESPAWN.
- GOAL: same hold as DYING, then RESPAWN. Lives unchanged. `player_dead` is ignored.
- OVER: `gameOver`=1, `playerDisable`=1. On `press`: go to IDLE. The game restarts on the next press from IDLE.
- Enables, registered, nonzero only in PLAY:
  - up = `vPos` ≥ V_MIN+STEP
  - down = `vPos`+STEP ≤ V_MAX
  - left = `hPos` ≥ H_MIN+STEP
  - right = `hPos`+STEP ≤ H_MAX
  - Compares use 13-bit arithmetic so that `pos+STEP` cannot wrap.
- Score saturates at 255. Lives never decrement below 0.

## Timing

- Reset values:
  - `state`=IDLE, `playerDisable`=1, `playerRst`=0
  - all enables 0, `lives`=0, `score`=0, `gameOver`=0
  - `bestV`=V_MAX, `btnsPrev`=0, hold counter=0
- All outputs are registered and change on the `slowClk` edge following the causing input.
- `press` seen at edge N gives state RESPAWN after N; `playerRst`=1 for the tick N..N+1; state is PLAY after N+1.
- Enables lag `hPos`/`vPos` by one tick. In the first PLAY tick they reflect the position sampled in RESPAWN.
- Hold counter clears on entry to DYING/GOAL. The state exits on the edge where counter==HOLD_TICKS−1, so the state is held for exactly HOLD_TICKS ticks.
- `rst` mid-operation (any state, including DYING with the counter partially run) returns everything to reset values on the next edge. `rst` overrides `press`.
- A `btns` press during DYING/GOAL/PLAY/RESPAWN has no effect, but it updates `btnsPrev`.

## Test plan

- Reset: assert `rst` 2 ticks with `btns`=4'b1111 → `state`=0, `playerDisable`=1, `lives`=0, `score`=0, all enables 0. Releasing `rst` with `btns` still held → no start.
- Start: in IDLE, `btns` 0→4'b0001 → next tick `state`=1, `playerRst`=1, `lives`=3; tick after, `state`=2, `playerRst`=0.
- Bounds: in PLAY with `hPos`=128, `vPos`=456 → one tick later left=0, down=0, right=1, up=1. With `hPos`=500, `vPos`=24 → right=0, up=1.
- Progress/goal: `vPos` 456→444→432 → `score`=2. Then `vPos`=12 → `score`=12, `state`=4 for 16 ticks, then RESPAWN, `lives`=3.
- Death sequence: pulse `player_dead` three times across games → `lives` 2,1,0, then `state`=5 with `gameOver`=1. Also drive `player_dead`=1 and `vPos`=12 in the same tick → DYING, score unchanged.
- Reset mid-DYING at hold count 7 → all reset values. A fresh press then gives `lives`=3.
